dpram_copy_dma: RTL

- Initiator-side block that drives both ports of the team's dual-port RAM (enable=1 write, enable=0 read, q registered one cycle after the address is sampled, q cleared on reset).
- Copies a block of len words from src_addr to dst_addr. Port 1 is read-only and port 2 is write-only, pipelined at 1 word/clk.
- Overlapping ranges are handled with memmove semantics; addresses wrap modulo 2**ADDR_WIDTH.
- Sits between a control/CPU-side register block and the RAM instance.

---
 rtl/dpram_copy_dma.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dpram_copy_dma.sv
// dpram_copy_dma: memmove-style block copy across the two ports of a dual-port RAM.
// Port 1 only reads and port 2 only writes, pipelined at one word per clock.
// Optional build macro DMA_FILL_EN adds a fill mode that writes a constant word
// over the destination range without reading.
module dpram_copy_dma #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] len,
`ifdef DMA_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] data1,
  output logic                  enable1,
  input  logic [DATA_WIDTH-1:0] q1,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic [DATA_WIDTH-1:0] data2,
  output logic                  enable2,
  input  logic [DATA_WIDTH-1:0] q2
);

  localparam logic [ADDR_WIDTH-1:0] One = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;  // next write address to present on port 2
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;        // words left to issue, including the current one
  logic                  desc_q, desc_d;
  logic                  en2_q, en2_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  fill_mode;

  // Direction decision taken from the live request inputs in IDLE.
  logic [ADDR_WIDTH-1:0] diff;
  logic                  is_desc;
  logic [ADDR_WIDTH-1:0] off0;
  logic [ADDR_WIDTH-1:0] rd_step;
  logic [ADDR_WIDTH-1:0] wr_step;

  assign diff    = dst_addr - src_addr;
  assign is_desc = (diff != '0) && (diff < len);
  assign off0    = is_desc ? len - One : '0;
  assign rd_step = desc_q ? addr1_q - One : addr1_q + One;
  assign wr_step = desc_q ? wr_ptr_q - One : wr_ptr_q + One;

`ifdef DMA_FILL_EN
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  assign fill_mode = fill_q;
  assign data2     = fill_q ? fill_data_q : q1;

  // Fill request and word are captured with start.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end
`else
  assign fill_mode = 1'b0;
  assign data2     = q1;
`endif

  // Next-state logic: request decode, read issue and write pipeline.
  always_comb begin
    state_d  = state_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    wr_ptr_d = wr_ptr_q;
    rem_d    = rem_q;
    desc_d   = desc_q;
    en2_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef DMA_FILL_EN
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
`ifdef DMA_FILL_EN
            fill_d      = fill;
            fill_data_d = fill_data;
            if (fill) begin
              // First write goes out immediately; no reads are needed.
              desc_d   = 1'b0;
              en2_d    = 1'b1;
              addr2_d  = dst_addr;
              wr_ptr_d = dst_addr + One;
              rem_d    = len - One;
              state_d  = (len == One) ? StDrain : StRun;
            end else begin
`endif
              desc_d   = is_desc;
              addr1_d  = src_addr + off0;
              wr_ptr_d = dst_addr + off0;
              rem_d    = len;
              state_d  = StRun;
`ifdef DMA_FILL_EN
            end
`endif
          end
        end
      end
      StRun: begin
        // The word read at this edge (or the next fill word) is written next cycle.
        en2_d    = 1'b1;
        addr2_d  = wr_ptr_q;
        wr_ptr_d = wr_step;
        rem_d    = rem_q - One;
        if (rem_q == One) begin
          state_d = StDrain;
        end else if (!fill_mode) begin
          addr1_d = rd_step;
        end
      end
      StDrain: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wr_ptr_q <= '0;
      rem_q    <= '0;
      desc_q   <= 1'b0;
      en2_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      wr_ptr_q <= wr_ptr_d;
      rem_q    <= rem_d;
      desc_q   <= desc_d;
      en2_q    <= en2_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;
  assign addr1   = addr1_q;
  assign data1   = '0;
  assign enable1 = 1'b0;
  assign addr2   = addr2_q;
  assign enable2 = en2_q;

  // Port-2 read data is never consumed.
  logic unused_q2;
  assign unused_q2 = ^q2;

endmodule
